// File: rtl/store_pkg.sv
// Shared types for the store path: request size, fault cause and FSM state encodings.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ALIGN   = 2'b01,
    CAUSE_BUS     = 2'b10,
    CAUSE_TIMEOUT = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10,
    ST_FAULT = 2'b11
  } state_e;

endpackage

// File: rtl/store_lane_align.sv
// Byte-lane replication, strobe generation and alignment check for a store request.
module store_lane_align
  import store_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  strb,
  output logic        misaligned
);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    wdata      = data;
    strb       = 4'b1111;
    misaligned = 1'b0;
    unique case (size)
      SZ_BYTE: begin
        wdata = {4{data[7:0]}};
        strb  = 4'b0001 << offset;
      end
      SZ_HALF: begin
        wdata      = {2{data[15:0]}};
        strb       = 4'b0011 << offset;
        misaligned = offset[0];
      end
      SZ_WORD: begin
        misaligned = (offset != 2'b00);
      end
      default: begin
        strb       = 4'b0000;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: one handshaked data-memory write per request, with alignment and bus fault reporting.
// Optional RESP-state timeout is built only when STORE_TIMEOUT_EN is defined.
module store_unit
  import store_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_bvalid,
  input  logic              mem_berr,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_cause,
  output logic [ADDR_W-1:0] err_addr
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  cause_e            cause_q, cause_d;

  logic [31:0] lane_wdata;
  logic [3:0]  lane_strb;
  logic        lane_misaligned;
  logic        timeout_hit;

  store_lane_align u_align (
    .size       (size_e'(req_size)),
    .offset     (req_addr[1:0]),
    .data       (req_data),
    .wdata      (lane_wdata),
    .strb       (lane_strb),
    .misaligned (lane_misaligned)
  );

`ifdef STORE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Cleared while waiting in ISSUE so it starts at zero on entry to RESP.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_ISSUE)     cnt_d = '0;
    else if (state_q == ST_RESP) cnt_d = cnt_q + CNT_W'(1);
  end

  assign timeout_hit = (state_q == ST_RESP) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  wire unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
  assign timeout_hit = 1'b0;
`endif

  assign req_ready  = (state_q == ST_IDLE);
  assign mem_wvalid = (state_q == ST_ISSUE);
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_cause  = cause_q;
  assign err_addr   = err_addr_q;

  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    err_addr_d = err_addr_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cause_d    = CAUSE_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          waddr_d    = {req_addr[ADDR_W-1:2], 2'b00};
          wdata_d    = lane_wdata;
          err_addr_d = req_addr;
          if (lane_misaligned) begin
            wstrb_d = 4'b0000;
            state_d = ST_FAULT;
            done_d  = 1'b1;
            err_d   = 1'b1;
            cause_d = CAUSE_ALIGN;
          end else begin
            wstrb_d = lane_strb;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (mem_wready) state_d = ST_RESP;
      end
      ST_RESP: begin
        // A response on the expiry cycle still completes normally.
        if (mem_bvalid) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = mem_berr;
          cause_d = mem_berr ? CAUSE_BUS : CAUSE_NONE;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so it sits inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      err_addr_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cause_q    <= CAUSE_NONE;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      err_addr_q <= err_addr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cause_q    <= cause_d;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed testbench for store_unit: lane/strobe vectors, stalls, faults, back-to-back and reset cases.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_bvalid;
  logic        mem_berr;
  logic        done;
  logic        err;
  logic [1:0]  err_cause;
  logic [31:0] err_addr;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_size   (req_size),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_bvalid (mem_bvalid),
    .mem_berr   (mem_berr),
    .done       (done),
    .err        (err),
    .err_cause  (err_cause),
    .err_addr   (err_addr)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    req_valid = 1'b1;
    req_addr  = addr;
    req_data  = data;
    req_size  = size;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    check({tag, " wvalid"}, 32'(mem_wvalid), 32'd0);
    check({tag, " waddr"}, mem_waddr, 32'h0);
    check({tag, " wdata"}, mem_wdata, 32'h0);
    check({tag, " wstrb"}, 32'(mem_wstrb), 32'h0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " err"}, 32'(err), 32'd0);
    check({tag, " cause"}, 32'(err_cause), 32'd0);
    check({tag, " err_addr"}, err_addr, 32'h0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    mem_wready = 1'b0; mem_bvalid = 1'b0; mem_berr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_reset_values("reset");

    // Byte store at offset 3, single-cycle wready and bvalid.
    request(32'h1003, 32'h0000_00A5, 2'b00);
    tick();
    req_valid = 1'b0;
    check("sb wvalid", 32'(mem_wvalid), 32'd1);
    check("sb ready", 32'(req_ready), 32'd0);
    check("sb waddr", mem_waddr, 32'h1000);
    check("sb wdata", mem_wdata, 32'hA5A5_A5A5);
    check("sb wstrb", 32'(mem_wstrb), 32'h8);
    mem_wready = 1'b1;
    tick();
    mem_wready = 1'b0;
    check("sb resp wvalid", 32'(mem_wvalid), 32'd0);
    check("sb resp done", 32'(done), 32'd0);
    mem_bvalid = 1'b1;
    tick();
    mem_bvalid = 1'b0;
    check("sb done", 32'(done), 32'd1);
    check("sb err", 32'(err), 32'd0);
    check("sb cause", 32'(err_cause), 32'd0);
    check("sb ready back", 32'(req_ready), 32'd1);
    check("sb err_addr", err_addr, 32'h1003);
    tick();
    check("sb done drop", 32'(done), 32'd0);

    // Half store at offset 2 with wready stalled for 5 cycles; stray bvalid in ISSUE ignored.
    request(32'h2002, 32'h1234_BEEF, 2'b01);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_bvalid = (i == 2);
      check("sh stall wvalid", 32'(mem_wvalid), 32'd1);
      check("sh stall waddr", mem_waddr, 32'h2000);
      check("sh stall wdata", mem_wdata, 32'hBEEF_BEEF);
      check("sh stall wstrb", 32'(mem_wstrb), 32'hC);
      check("sh stall done", 32'(done), 32'd0);
      tick();
    end
    mem_bvalid = 1'b0;
    check("sh still issue", 32'(mem_wvalid), 32'd1);
    mem_wready = 1'b1;
    tick();
    mem_wready = 1'b0;
    mem_bvalid = 1'b1;
    tick();
    mem_bvalid = 1'b0;
    check("sh done", 32'(done), 32'd1);
    check("sh err", 32'(err), 32'd0);
    tick();

    // Misaligned word store: no bus activity, fault reported one edge after accept.
    request(32'h3001, 32'hCAFE_F00D, 2'b10);
    tick();
    req_valid = 1'b0;
    check("sw mis wvalid", 32'(mem_wvalid), 32'd0);
    check("sw mis wstrb", 32'(mem_wstrb), 32'h0);
    check("sw mis done", 32'(done), 32'd1);
    check("sw mis err", 32'(err), 32'd1);
    check("sw mis cause", 32'(err_cause), 32'd1);
    check("sw mis err_addr", err_addr, 32'h3001);
    tick();
    check("sw mis done drop", 32'(done), 32'd0);
    check("sw mis ready", 32'(req_ready), 32'd1);

    // Misaligned half and illegal size.
    request(32'h2201, 32'h0000_1111, 2'b01);
    tick();
    req_valid = 1'b0;
    check("sh mis cause", 32'(err_cause), 32'd1);
    check("sh mis wvalid", 32'(mem_wvalid), 32'd0);
    tick();
    request(32'h5000, 32'h0000_0001, 2'b11);
    tick();
    req_valid = 1'b0;
    check("ill done", 32'(done), 32'd1);
    check("ill cause", 32'(err_cause), 32'd1);
    check("ill wstrb", 32'(mem_wstrb), 32'h0);
    tick();

    // Word store with bus error, then a back-to-back byte store accepted in the done cycle.
    request(32'h4000, 32'hDEAD_BEEF, 2'b10);
    tick();
    req_valid = 1'b0;
    check("sw wdata", mem_wdata, 32'hDEAD_BEEF);
    check("sw wstrb", 32'(mem_wstrb), 32'hF);
    mem_wready = 1'b1;
    tick();
    mem_wready = 1'b0;
    mem_bvalid = 1'b1;
    mem_berr   = 1'b1;
    tick();
    mem_bvalid = 1'b0;
    mem_berr   = 1'b0;
    check("berr done", 32'(done), 32'd1);
    check("berr err", 32'(err), 32'd1);
    check("berr cause", 32'(err_cause), 32'd2);
    check("berr ready", 32'(req_ready), 32'd1);
    request(32'h6001, 32'h0000_003C, 2'b00);
    tick();
    req_valid = 1'b0;
    check("b2b done drop", 32'(done), 32'd0);
    check("b2b err drop", 32'(err), 32'd0);
    check("b2b wvalid", 32'(mem_wvalid), 32'd1);
    check("b2b waddr", mem_waddr, 32'h6000);
    check("b2b wdata", mem_wdata, 32'h3C3C_3C3C);
    check("b2b wstrb", 32'(mem_wstrb), 32'h2);
    mem_wready = 1'b1;
    tick();
    mem_wready = 1'b0;
    mem_bvalid = 1'b1;
    tick();
    mem_bvalid = 1'b0;
    check("b2b done", 32'(done), 32'd1);
    check("b2b err", 32'(err), 32'd0);
    check("b2b err_addr", err_addr, 32'h6001);
    tick();

    // Reset while in ISSUE, then a stray bvalid.
    request(32'h7000, 32'h0102_0304, 2'b10);
    tick();
    req_valid = 1'b0;
    check("rst issue pre", 32'(mem_wvalid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("rst issue");
    mem_bvalid = 1'b1;
    tick();
    mem_bvalid = 1'b0;
    check("rst issue stray done", 32'(done), 32'd0);
    check("rst issue stray ready", 32'(req_ready), 32'd1);

    // Reset while in RESP, then a stray bvalid.
    request(32'h8004, 32'h5566_7788, 2'b10);
    tick();
    req_valid = 1'b0;
    mem_wready = 1'b1;
    tick();
    mem_wready = 1'b0;
    check("rst resp pre", 32'(req_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("rst resp");
    mem_bvalid = 1'b1;
    tick();
    mem_bvalid = 1'b0;
    check("rst resp stray done", 32'(done), 32'd0);
    tick();
    check("rst resp idle done", 32'(done), 32'd0);

`ifdef STORE_TIMEOUT_EN
    // No response: timeout fires exactly 4 edges after entering RESP.
    request(32'h9000, 32'h0000_0000, 2'b10);
    tick();
    req_valid = 1'b0;
    mem_wready = 1'b1;
    tick();
    mem_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to wait done", 32'(done), 32'd0);
    end
    tick();
    check("to done", 32'(done), 32'd1);
    check("to err", 32'(err), 32'd1);
    check("to cause", 32'(err_cause), 32'd3);
    check("to ready", 32'(req_ready), 32'd1);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
